// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampling UART receiver.
// Parity modes, FSM state encoding, error flags and the bit-period helper.
package uart_pkg;

  localparam int UART_CHECK_NONE = 0;
  localparam int UART_CHECK_ODD  = 1;
  localparam int UART_CHECK_EVEN = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DELIVER
  } rx_state_t;

  typedef struct packed {
    logic parity;
    logic frame;
    logic overrun;
  } rx_err_t;

  function automatic int clk_per_bit(input int clk, input int baud);
    return clk / baud;
  endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// User-side handshake and status bundle of the UART receiver.
// The master is the receiver; the slave is the consuming logic.
interface uart_rx_os_if #(
  parameter int P_UART_DATA_WIDTH = 8
);
  logic                         i_user_rx_ready;
  logic [P_UART_DATA_WIDTH-1:0] o_user_rx_data;
  logic                         o_user_rx_valid;
  logic                         o_parity_err;
  logic                         o_frame_err;
  logic                         o_overrun_err;
  logic                         o_busy;

  modport master (
    input  i_user_rx_ready,
    output o_user_rx_data, o_user_rx_valid, o_parity_err, o_frame_err, o_overrun_err, o_busy
  );

  modport slave (
    output i_user_rx_ready,
    input  o_user_rx_data, o_user_rx_valid, o_parity_err, o_frame_err, o_overrun_err, o_busy
  );
endinterface

// File: rtl/uart_rx_sampler.sv
// Line synchroniser, falling-edge detect, bit-period counter and 3-sample
// majority vote around mid-bit.
module uart_rx_sampler #(
  parameter int CLK_PER_BIT = 10
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic rx,
  input  logic restart,
  output logic line_hi,
  output logic fall,
  output logic bit_val,
  output logic bit_done,
  output logic bit_end
);
  localparam int MID = CLK_PER_BIT / 2;
  localparam int CW  = $clog2(CLK_PER_BIT);

  // sync[0..1] is the 2-FF synchroniser, sync[2] the delayed copy for edges
  logic [2:0]    sync;
  logic [CW-1:0] clk_cnt;
  logic          samp0, samp1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync    <= '1;
      clk_cnt <= '0;
      samp0   <= 1'b1;
      samp1   <= 1'b1;
    end else begin
      sync <= {sync[1:0], rx};
      if (restart || bit_end) clk_cnt <= '0;
      else                    clk_cnt <= clk_cnt + CW'(1);
      if (clk_cnt == CW'(MID - 1)) samp0 <= sync[1];
      if (clk_cnt == CW'(MID))     samp1 <= sync[1];
    end
  end

  assign line_hi  = sync[1];
  assign fall     = sync[2] & ~sync[1];
  assign bit_done = (clk_cnt == CW'(MID + 1));
  assign bit_end  = (clk_cnt == CW'(CLK_PER_BIT - 1));
  assign bit_val  = (samp0 & samp1) | (samp0 & sync[1]) | (samp1 & sync[1]);

endmodule

// File: rtl/uart_rx_os.sv
// UART receiver with configurable frame format, glitch-rejecting start
// detection, error reporting and a one-entry valid/ready output register.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int P_SYSTEM_CLK      = 50_000_000,
  parameter int P_UART_BUADRATE   = 9600,
  parameter int P_UART_DATA_WIDTH = 8,
  parameter int P_UART_STOP_WIDTH = 1,
  parameter int P_UART_CHECK      = 0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_uart_rx,
  uart_rx_os_if.master u
);
  localparam int CPB = clk_per_bit(P_SYSTEM_CLK, P_UART_BUADRATE);
  localparam int W   = P_UART_DATA_WIDTH;
  localparam int SW  = P_UART_STOP_WIDTH;

  rx_state_t      state, nxt;
  rx_err_t        err;
  logic           line_hi, fall, bit_val, bit_done, bit_end;
  logic           armed, start_go, load, par_mis;
  logic [3:0]     bit_idx;
  logic           stop_idx;
  logic [W-1:0]   shreg, data_q;
  logic           valid_q, par_bit, frame_bad;

  assign start_go = (state == IDLE) && armed && fall;

  uart_rx_sampler #(.CLK_PER_BIT(CPB)) u_smp (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .rx       (i_uart_rx),
    .restart  (start_go),
    .line_hi  (line_hi),
    .fall     (fall),
    .bit_val  (bit_val),
    .bit_done (bit_done),
    .bit_end  (bit_end)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (armed && fall) nxt = START;
      START:   if (bit_done && bit_val) nxt = IDLE;
               else if (bit_end)        nxt = DATA;
      DATA:    if (bit_end && bit_idx == 4'(W - 1))
                 nxt = (P_UART_CHECK != UART_CHECK_NONE) ? PARITY : STOP;
      PARITY:  if (bit_end) nxt = STOP;
      STOP:    if (bit_done && stop_idx == 1'(SW - 1)) nxt = DELIVER;
      DELIVER: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Odd parity wants the data+parity XOR to be 1, even wants it 0
  always_comb begin
    par_mis = 1'b0;
    if (P_UART_CHECK == UART_CHECK_ODD)  par_mis = ~(^shreg ^ par_bit);
    if (P_UART_CHECK == UART_CHECK_EVEN) par_mis =  (^shreg ^ par_bit);
  end

  always_comb begin
    err  = '0;
    load = 1'b0;
    if (state == DELIVER) begin
      if (frame_bad)                         err.frame   = 1'b1;
      else if (par_mis)                      err.parity  = 1'b1;
      else if (valid_q && !u.i_user_rx_ready) err.overrun = 1'b1;
      else                                   load        = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      armed     <= 1'b0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      frame_bad <= 1'b0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      // A break leaves the line low; stay deaf until it has gone high again
      if (err.frame)    armed <= 1'b0;
      else if (line_hi) armed <= 1'b1;

      unique case (state)
        IDLE: begin
          bit_idx   <= '0;
          stop_idx  <= 1'b0;
          frame_bad <= 1'b0;
        end
        DATA: begin
          if (bit_done) shreg   <= {bit_val, shreg[W-1:1]};
          if (bit_end)  bit_idx <= bit_idx + 4'd1;
        end
        PARITY: if (bit_done) par_bit <= bit_val;
        STOP: begin
          if (bit_done && !bit_val) frame_bad <= 1'b1;
          if (bit_end)              stop_idx  <= 1'b1;
        end
        default: ;
      endcase

      if (load) begin
        data_q  <= shreg;
        valid_q <= 1'b1;
      end else if (valid_q && u.i_user_rx_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign u.o_user_rx_data  = data_q;
  assign u.o_user_rx_valid = valid_q;
  assign u.o_parity_err    = err.parity;
  assign u.o_frame_err     = err.frame;
  assign u.o_overrun_err   = err.overrun;
  assign u.o_busy          = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench: five receivers (8N1, 8E1, 8N2, 7O1, 5N1) at 10 clocks
// per bit, with a scoreboard of expected words and error pulses.
module tb_uart_rx_os;
  localparam logic [4:0][3:0] DWS = {4'd5, 4'd7, 4'd8, 4'd8, 4'd8};
  localparam logic [4:0][3:0] SWS = {4'd1, 4'd1, 4'd2, 4'd1, 4'd1};
  localparam logic [4:0][3:0] PCS = {4'd0, 4'd1, 4'd0, 4'd2, 4'd0};

  logic            clk, rst;
  logic [4:0]      line, rdy, vld, perr, ferr, oerr, busy;
  logic [4:0][8:0] dat;
  logic [4:0]      pv, acc;
  int              exp_q[$];
  int              n_chk, n_err, gl_n;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    localparam int W = int'(DWS[g]);
    uart_rx_os_if #(.P_UART_DATA_WIDTH(W)) uif ();
    uart_rx_os #(
      .P_SYSTEM_CLK      (1_000_000),
      .P_UART_BUADRATE   (100_000),
      .P_UART_DATA_WIDTH (W),
      .P_UART_STOP_WIDTH (int'(SWS[g])),
      .P_UART_CHECK      (int'(PCS[g]))
    ) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_uart_rx (line[g]),
      .u         (uif.master)
    );
    assign uif.i_user_rx_ready = rdy[g];
    assign vld[g]  = uif.o_user_rx_valid;
    assign perr[g] = uif.o_parity_err;
    assign ferr[g] = uif.o_frame_err;
    assign oerr[g] = uif.o_overrun_err;
    assign busy[g] = uif.o_busy;
    assign dat[g]  = 9'(uif.o_user_rx_data);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // event code: instance, kind (0 word, 1 parity, 2 frame, 3 overrun), data
  function automatic int ev(input int id, input int kind, input int d);
    return id * 4096 + kind * 512 + d;
  endfunction

  task automatic expect_ev(input int id, input int kind, input int d);
    exp_q.push_back(ev(id, kind, d));
  endtask

  task automatic got(input int id, input int kind, input int d);
    int e;
    if (exp_q.size() == 0) chk("sb_unexpected", ev(id, kind, d), -1);
    else begin
      e = exp_q.pop_front();
      chk("sb_event", ev(id, kind, d), e);
    end
  endtask

  always @(posedge clk) begin
    pv  <= vld;
    acc <= vld & rdy;
  end

  // a new word is valid rising, or valid still high right after an accept
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      for (int i = 0; i < 5; i++) begin
        if (vld[i] && (!pv[i] || acc[i])) got(i, 0, int'(dat[i]));
        if (perr[i]) got(i, 1, 0);
        if (ferr[i]) got(i, 2, 0);
        if (oerr[i]) got(i, 3, 0);
      end
    end
  end

  task automatic send(input int id, input int d, input int w, input int par,
                      input int ns, input bit badpar, input logic [1:0] stopv);
    logic [15:0] fb;
    int          nb;
    logic        p;
    fb = '0;
    nb = 1;
    for (int i = 0; i < w; i++) begin
      fb[nb] = d[i];
      nb++;
    end
    if (par != 0) begin
      p = 1'b0;
      for (int i = 0; i < w; i++) p = p ^ d[i];
      if (par == 1) p = ~p;
      if (badpar)   p = ~p;
      fb[nb] = p;
      nb++;
    end
    for (int k = 0; k < ns; k++) begin
      fb[nb] = stopv[k];
      nb++;
    end
    @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      line[id] = fb[i];
      repeat (10) @(negedge clk);
    end
  endtask

  initial begin
    n_chk = 0; n_err = 0; gl_n = 0;
    line = '1; rdy = '1; rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_vld", int'(vld), 0);
    chk("rst_dat", int'(dat[0]), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 8N1 word with exact delivery timing
    expect_ev(0, 0, 'hA5);
    fork
      send(0, 'hA5, 8, 0, 1, 1'b0, 2'b11);
      begin
        repeat (101) @(negedge clk);
        chk("t1_busy_dlv", int'(busy[0]), 1);
        @(negedge clk);
        chk("t1_busy_end", int'(busy[0]), 0);
        chk("t1_vld", int'(vld[0]), 1);
        chk("t1_dat", int'(dat[0]), 'hA5);
        @(negedge clk);
        chk("t1_vld_pulse", int'(vld[0]), 0);
      end
    join
    repeat (10) @(negedge clk);

    // 8E1 good then bad parity
    expect_ev(1, 0, 'h3C);
    send(1, 'h3C, 8, 2, 1, 1'b0, 2'b11);
    repeat (10) @(negedge clk);
    expect_ev(1, 1, 0);
    send(1, 'h3C, 8, 2, 1, 1'b1, 2'b11);
    repeat (10) @(negedge clk);
    chk("t2_vld", int'(vld[1]), 0);

    // 8N2 with low second stop bit, then a break, then a clean frame
    expect_ev(2, 2, 0);
    send(2, 'h55, 8, 0, 2, 1'b0, 2'b01);
    repeat (30) @(negedge clk);
    chk("t3_break_idle", int'(busy[2]), 0);
    chk("t3_vld", int'(vld[2]), 0);
    line[2] = 1'b1;
    repeat (10) @(negedge clk);
    expect_ev(2, 0, 'h12);
    send(2, 'h12, 8, 0, 2, 1'b0, 2'b11);
    repeat (10) @(negedge clk);

    // start-bit glitch
    fork
      begin
        @(negedge clk);
        line[0] = 1'b0;
        repeat (4) @(negedge clk);
        line[0] = 1'b1;
      end
      repeat (30) begin
        @(negedge clk);
        if (busy[0]) gl_n++;
      end
    join
    chk("t4_busy_cycles", gl_n, 7);
    chk("t4_vld", int'(vld[0]), 0);

    // overrun with ready low, then accept on the delivery cycle
    rdy[0] = 1'b0;
    expect_ev(0, 0, 'h11);
    send(0, 'h11, 8, 0, 1, 1'b0, 2'b11);
    repeat (10) @(negedge clk);
    expect_ev(0, 3, 0);
    send(0, 'h22, 8, 0, 1, 1'b0, 2'b11);
    repeat (10) @(negedge clk);
    chk("t5_hold_dat", int'(dat[0]), 'h11);
    chk("t5_hold_vld", int'(vld[0]), 1);
    expect_ev(0, 0, 'h22);
    fork
      send(0, 'h22, 8, 0, 1, 1'b0, 2'b11);
      begin
        repeat (101) @(negedge clk);
        rdy[0] = 1'b1;
        @(negedge clk);
        rdy[0] = 1'b0;
      end
    join
    repeat (5) @(negedge clk);
    chk("t5_sim_dat", int'(dat[0]), 'h22);
    chk("t5_sim_vld", int'(vld[0]), 1);
    rdy[0] = 1'b1;
    @(negedge clk);
    chk("t5_accept", int'(vld[0]), 0);

    // 7O1 held word, parity error beats overrun, 5-bit words and reset abort
    rdy[3] = 1'b0;
    expect_ev(3, 0, 'h5A);
    send(3, 'h5A, 7, 1, 1, 1'b0, 2'b11);
    repeat (10) @(negedge clk);
    chk("t6_dat7", int'(dat[3]), 'h5A);
    expect_ev(3, 1, 0);
    send(3, 'h2B, 7, 1, 1, 1'b1, 2'b11);
    repeat (10) @(negedge clk);
    chk("t6_dat7_kept", int'(dat[3]), 'h5A);
    expect_ev(4, 0, 'h15);
    send(4, 'h15, 5, 0, 1, 1'b0, 2'b11);
    repeat (10) @(negedge clk);
    fork
      send(4, 'h1F, 5, 0, 1, 1'b0, 2'b11);
      begin
        repeat (40) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    join
    chk("t6_rst_dat", int'(dat[3]), 0);
    chk("t6_rst_vld", int'(vld), 0);
    chk("t6_rst_busy", int'(busy), 0);
    repeat (10) @(negedge clk);
    expect_ev(4, 0, 'h0B);
    send(4, 'h0B, 5, 0, 1, 1'b0, 2'b11);
    repeat (10) @(negedge clk);
    chk("t6_dat5", int'(dat[4]), 'h0B);

    repeat (5) @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
